// File: rtl/scroll_scheduler.sv
// Game-state sequencer for the scrolling terrain: owns scroll position, speed,
// lap count and per-lap coin availability, advanced by a synchronized frame tick.
//
// state  | meaning
// IDLE   | waiting for start; all counters held at their initial values
// RUN    | scrolling; frame ticks advance position, coins can be collected
// PAUSED | everything frozen until the next pause press
// DEAD   | frozen after a collision; start accepted once the dead timer is full
module scroll_scheduler #(
  parameter int FRAME_MAX   = 3095,
  parameter int SPEED_INIT  = 2,
  parameter int SPEED_MAX   = 6,
  parameter int DEAD_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        pause,
  input  logic        collision,
  input  logic [2:0]  coin_hit,
  output logic [11:0] frame_counter,
  output logic        playing,
  output logic [2:0]  CoinStatus,
  output logic [2:0]  speed,
  output logic [3:0]  lap_count,
  output logic [1:0]  state
);

  localparam int TW = $clog2(DEAD_FRAMES + 1);
  localparam logic [12:0]   FRAME_LAST = 13'(FRAME_MAX);
  localparam logic [12:0]   FRAME_WRAP = 13'(FRAME_MAX + 1);
  localparam logic [2:0]    SPD_INIT   = 3'(SPEED_INIT);
  localparam logic [2:0]    SPD_MAX    = 3'(SPEED_MAX);
  localparam logic [TW-1:0] DEAD_FULL  = TW'(DEAD_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t        state_q, state_nx;
  logic [11:0]   frame_nx;
  logic [2:0]    speed_nx, coins_nx;
  logic [3:0]    lap_nx;
  logic [TW-1:0] timer_q, timer_nx;
  logic          playing_nx;
  logic          fs1, fs2, fs3, pause_d;
  logic          tick, pause_edge;
  logic [12:0]   sum;

  // frame_clk is asynchronous to Clk: two-flop synchronizer plus edge detect
  assign tick       = fs2 & ~fs3;
  assign pause_edge = pause & ~pause_d;
  assign sum        = {1'b0, frame_counter} + {10'd0, speed};
  assign state      = state_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1           <= 1'b0;
      fs2           <= 1'b0;
      fs3           <= 1'b0;
      pause_d       <= 1'b0;
      state_q       <= IDLE;
      frame_counter <= 12'd0;
      speed         <= SPD_INIT;
      lap_count     <= 4'd0;
      CoinStatus    <= 3'b111;
      playing       <= 1'b0;
      timer_q       <= '0;
    end else begin
      fs1           <= frame_clk;
      fs2           <= fs1;
      fs3           <= fs2;
      pause_d       <= pause;
      state_q       <= state_nx;
      frame_counter <= frame_nx;
      speed         <= speed_nx;
      lap_count     <= lap_nx;
      CoinStatus    <= coins_nx;
      playing       <= playing_nx;
      timer_q       <= timer_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    frame_nx = frame_counter;
    speed_nx = speed;
    lap_nx   = lap_count;
    coins_nx = CoinStatus;
    timer_nx = timer_q;
    case (state_q)
      IDLE: begin
        frame_nx = 12'd0;
        speed_nx = SPD_INIT;
        lap_nx   = 4'd0;
        coins_nx = 3'b111;
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (collision) begin
          state_nx = DEAD;
          timer_nx = '0;
        end else begin
          if (pause_edge) state_nx = PAUSED;
          coins_nx = CoinStatus & ~coin_hit;
          if (tick) begin
            if (sum > FRAME_LAST) begin
              // wrap restores every coin, overriding any hit this cycle
              frame_nx = 12'(sum - FRAME_WRAP);
              coins_nx = 3'b111;
              if (lap_count != 4'hF) lap_nx = lap_count + 4'd1;
              if (speed < SPD_MAX) speed_nx = speed + 3'd1;
            end else begin
              frame_nx = sum[11:0];
            end
          end
        end
      end
      PAUSED: begin
        if (pause_edge) state_nx = RUN;
      end
      DEAD: begin
        if (tick && timer_q < DEAD_FULL) timer_nx = TW'(timer_q + 1'b1);
        if (start && timer_q == DEAD_FULL) begin
          state_nx = IDLE;
          frame_nx = 12'd0;
          speed_nx = SPD_INIT;
          lap_nx   = 4'd0;
          coins_nx = 3'b111;
        end
      end
      default: state_nx = IDLE;
    endcase
    playing_nx = (state_nx == RUN);
  end

endmodule

// File: doc/scroll_scheduler.md
Name: scroll_scheduler

Overview:
- Sequences the scrolling-terrain datapath: owns game state, the frame_counter scroll position, scroll speed, lap count and per-lap coin availability.
- Drives the terrain/coin renderer (frame_counter, CoinStatus, playing).
- Takes start/pause from the user input decoder and collision/coin-hit events from game logic.

Parameters:
- FRAME_MAX, 3095, last valid scroll position; scroll is modulo FRAME_MAX+1.
- SPEED_INIT, 2, pixels advanced per frame at game start.
- SPEED_MAX, 6, speed ceiling.
- DEAD_FRAMES, 60, minimum frames spent in DEAD before start is accepted.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync-rate frame clock (~60 Hz), asynchronous to Clk.
- start  in  1  level; begin/restart request.
- pause  in  1  level; toggle request, rising edge only.
- collision  in  1  pulse/level from game logic; stickman died.
- coin_hit  in  3  per-coin collection pulses from game logic.
- frame_counter  out  12  current scroll offset, 0..FRAME_MAX.
- playing  out  1  high only in RUN.
- CoinStatus  out  3  1 = coin i still present.
- speed  out  3  current step size.
- lap_count  out  4  completed laps, saturating.
- state  out  2  IDLE=0, RUN=1, PAUSED=2, DEAD=3.

Behaviour:
- Reset (Reset_n low, immediate): state=IDLE, frame_counter=0, speed=SPEED_INIT, lap_count=0, CoinStatus=3'b111, playing=0, dead timer=0, all sync flops=0.
- frame_clk path:
  - 2-flop synchronizer, then a delayed copy.
  - tick = rising edge of the synchronized signal; one Clk cycle wide.
  - tick asserts 3 Clk cycles after frame_clk rises.
- pause edge: registered copy of pause; pause_edge = pause & ~pause_d.
- IDLE:
  - frame_counter=0, speed=SPEED_INIT, lap_count=0, CoinStatus=111.
  - start=1 -> RUN on the next Clk.
- RUN, on each tick:
  - sum = frame_counter + speed, computed 13 bits wide.
  - sum <= FRAME_MAX: frame_counter = sum.
  - sum > FRAME_MAX: wrap event.
    - frame_counter = sum - (FRAME_MAX+1).
    - lap_count += 1, saturating at 15.
    - CoinStatus = 111.
    - speed = min(speed+1, SPEED_MAX); the new speed applies from the next tick.
  - No tick: frame_counter holds.
- RUN exits, priority collision > pause_edge:
  - collision -> DEAD; dead timer cleared; frame_counter frozen.
  - pause_edge -> PAUSED.
  - collision and tick in the same cycle: go to DEAD and do not advance.
- PAUSED:
  - All counters frozen; ticks ignored; coin_hit ignored.
  - pause_edge -> RUN.
  - collision ignored.
- DEAD:
  - Counters frozen.
  - Dead timer increments per tick, saturating at DEAD_FRAMES.
  - start=1 with timer==DEAD_FRAMES -> IDLE; start earlier is ignored.
- coin_hit:
  - In RUN only, CoinStatus[i] cleared the cycle after coin_hit[i]=1.
  - Multiple bits may clear in the same cycle.
  - A wrap and a coin_hit in the same cycle: the wrap wins (all coins restored).
- playing is a registered output: equals (state==RUN); updates the same edge as state.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-operation: immediate return to the reset values above, in any state.

Test Plan:
- Reset/start: release Reset_n, hold start=1 for 1 cycle -> state=RUN, playing=1, frame_counter=0, speed=2. Then 10 ticks -> frame_counter=20.
- Wrap: preload by ticking to frame_counter=3094, speed=2; one tick -> frame_counter=0, lap_count=1, speed=3, CoinStatus=111. The next tick -> 3. Also at 3093 with speed 3 -> wraps to 0.
- Pause: pause rising edge in RUN -> PAUSED. 5 ticks -> frame_counter unchanged. Second pause rising edge -> RUN. Held-high pause toggles only once.
- Collision priority: collision and pause_edge in the same cycle with a tick -> DEAD, frame_counter not advanced. start before 60 ticks -> stays DEAD. start after 60 ticks -> IDLE with frame_counter=0, lap_count=0.
- Coins: coin_hit=3'b010 in RUN -> CoinStatus=101. coin_hit=001 during PAUSED -> still 101. coin_hit coincident with wrap -> 111.
- Speed saturation: run 10 laps -> speed stays 6, lap_count=10. 20 laps -> lap_count=15.
- Async reset: drive Reset_n low between Clk edges in RUN -> all outputs at reset values before the next Clk edge.
